// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and lane record for the F->D pipeline register
//   NOP_INSTR : canonical RISC-V NOP (addi x0,x0,0) placed in empty/killed lanes
//   XLEN      : default PC width for lane_t
//   lane_t    : one decode lane {valid, instr, pc, pc4, taken}
package decode_pkg;
   localparam int XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic            valid;
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic            taken;
   } lane_t;
endpackage

// File: rtl/decode_lane_reg.sv
// decode_lane_reg: one lane of the F->D register with squash/hold/load control
//   clk, rst_n        : clock, async active-low reset
//   squash            : clear the lane (flush), wins over hold
//   hold              : keep all fields unchanged
//   valid, instr, pc,
//   taken, kill       : fetch-side lane inputs; kill drops the lane but keeps pc fields
//   valid_q, instr_q,
//   pc_q, pc4_q, taken_q : registered lane outputs
module decode_lane_reg
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            squash,
   input  logic            hold,
   input  logic            valid,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic            taken,
   input  logic            kill,
   output logic            valid_q,
   output logic [31:0]     instr_q,
   output logic [XLEN-1:0] pc_q,
   output logic [XLEN-1:0] pc4_q,
   output logic            taken_q
);
   logic live;
   assign live = valid & ~kill;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         pc4_q   <= '0;
         taken_q <= 1'b0;
      end else if (squash) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         pc4_q   <= '0;
         taken_q <= 1'b0;
      end else if (!hold) begin
         valid_q <= live;
         instr_q <= live ? instr : NOP_INSTR;
         pc_q    <= pc;
         pc4_q   <= pc + XLEN'(4);
         taken_q <= live & taken;
      end
   end
endmodule

// File: rtl/decode_stage_reg.sv
// decode_stage_reg: multi-lane F->D pipeline register with bubble NOPs, in-packet kill and pc+4
//   clk, rst_n : clock, async active-low reset
//   stall_d    : hold all lanes; flush_d : squash all lanes (flush beats stall)
//   valid_f, instr_f, pc_f, taken_f : fetch packet, lane i at slice i
//   valid_d, instr_d, pc_d, pc4_d, taken_d : registered decode packet
//   perf_clr, stall_cnt, flush_cnt, kill_cnt : saturating perf counters, present only
//   when DSTAGE_PERF_EN is defined
module decode_stage_reg
   import decode_pkg::*;
#(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_d,
   input  logic                  flush_d,
   input  logic [LANES-1:0]      valid_f,
   input  logic [LANES*32-1:0]   instr_f,
   input  logic [LANES*XLEN-1:0] pc_f,
   input  logic [LANES-1:0]      taken_f,
   output logic [LANES-1:0]      valid_d,
   output logic [LANES*32-1:0]   instr_d,
   output logic [LANES*XLEN-1:0] pc_d,
   output logic [LANES*XLEN-1:0] pc4_d,
   output logic [LANES-1:0]      taken_d
`ifdef DSTAGE_PERF_EN
   ,
   input  logic                  perf_clr,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [CNT_W-1:0]      kill_cnt
`endif
);
   logic [LANES-1:0] kill;
   logic             seen;
   // A lane is killed when any lower lane is a valid predicted-taken slot.
   always_comb begin
      kill = '0;
      seen = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         kill[i] = seen;
         seen    = seen | (valid_f[i] & taken_f[i]);
      end
   end
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      decode_lane_reg #(.XLEN(XLEN)) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .squash  (flush_d),
         .hold    (stall_d),
         .valid   (valid_f[g]),
         .instr   (instr_f[32*g +: 32]),
         .pc      (pc_f[XLEN*g +: XLEN]),
         .taken   (taken_f[g]),
         .kill    (kill[g]),
         .valid_q (valid_d[g]),
         .instr_q (instr_d[32*g +: 32]),
         .pc_q    (pc_d[XLEN*g +: XLEN]),
         .pc4_q   (pc4_d[XLEN*g +: XLEN]),
         .taken_q (taken_d[g])
      );
   end
`ifdef DSTAGE_PERF_EN
   logic [2:0] n_kill;
   always_comb begin
      n_kill = '0;
      for (int i = 0; i < LANES; i++) n_kill = n_kill + 3'(kill[i] & valid_f[i]);
   end
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + (CNT_W+1)'(b);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         kill_cnt  <= '0;
      end else if (perf_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         kill_cnt  <= '0;
      end else begin
         if (stall_d) stall_cnt <= sat_add(stall_cnt, 3'd1);
         if (flush_d) flush_cnt <= sat_add(flush_cnt, 3'd1);
         if (!stall_d && !flush_d) kill_cnt <= sat_add(kill_cnt, n_kill);
      end
   end
`endif
endmodule

// File: tb/tb_decode_stage_reg.sv
// tb_decode_stage_reg: directed + randomized check of decode_stage_reg against a packet-level model
module tb_decode_stage_reg;
   localparam int LANES = 2;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n, stall_d, flush_d, perf_clr;
   logic [LANES-1:0]      valid_f, taken_f, valid_d, taken_d;
   logic [LANES*32-1:0]   instr_f, instr_d;
   logic [LANES*XLEN-1:0] pc_f, pc_d, pc4_d;
   logic [CNT_W-1:0]      stall_cnt, flush_cnt, kill_cnt;

   logic [LANES-1:0]      m_valid, m_taken;
   logic [LANES*32-1:0]   m_instr;
   logic [LANES*XLEN-1:0] m_pc, m_pc4;
   int m_stall, m_flush, m_kill;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decode_stage_reg #(.LANES(LANES), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d),
      .valid_f(valid_f), .instr_f(instr_f), .pc_f(pc_f), .taken_f(taken_f),
      .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d), .taken_d(taken_d)
`ifdef DSTAGE_PERF_EN
      , .perf_clr(perf_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .kill_cnt(kill_cnt)
`endif
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return v > CMAX ? CMAX : v;
   endfunction

   task automatic model_reset();
      m_valid = '0; m_taken = '0; m_pc = '0; m_pc4 = '0;
      for (int i = 0; i < LANES; i++) m_instr[32*i +: 32] = NOP;
      m_stall = 0; m_flush = 0; m_kill = 0;
   endtask

   // Packet-level view: everything after the first valid predicted-taken slot is dropped.
   task automatic model_edge();
      bit found;
      int killed;
      logic [XLEN-1:0] p;
      found = 0;
      killed = 0;
      if (flush_d) model_flush();
      else if (!stall_d) begin
         for (int i = 0; i < LANES; i++) begin
            p = pc_f[XLEN*i +: XLEN];
            m_valid[i] = valid_f[i] && !found;
            if (valid_f[i] && found) killed++;
            m_instr[32*i +: 32] = m_valid[i] ? instr_f[32*i +: 32] : NOP;
            m_taken[i] = m_valid[i] && taken_f[i];
            m_pc[XLEN*i +: XLEN] = p;
            m_pc4[XLEN*i +: XLEN] = p + 32'd4;
            if (valid_f[i] && taken_f[i]) found = 1;
         end
      end
      if (perf_clr) begin
         m_stall = 0; m_flush = 0; m_kill = 0;
      end else begin
         if (stall_d) m_stall = sat(m_stall + 1);
         if (flush_d) m_flush = sat(m_flush + 1);
         if (!stall_d && !flush_d) m_kill = sat(m_kill + killed);
      end
   endtask

   task automatic model_flush();
      m_valid = '0; m_taken = '0; m_pc = '0; m_pc4 = '0;
      for (int i = 0; i < LANES; i++) m_instr[32*i +: 32] = NOP;
   endtask

   task automatic compare();
      check("valid_d", 128'(valid_d), 128'(m_valid));
      check("instr_d", 128'(instr_d), 128'(m_instr));
      check("pc_d", 128'(pc_d), 128'(m_pc));
      check("pc4_d", 128'(pc4_d), 128'(m_pc4));
      check("taken_d", 128'(taken_d), 128'(m_taken));
`ifdef DSTAGE_PERF_EN
      check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      check("flush_cnt", 128'(flush_cnt), 128'(m_flush));
      check("kill_cnt", 128'(kill_cnt), 128'(m_kill));
`endif
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic drive(input logic [LANES-1:0] v, input logic [LANES-1:0] t, input logic s, input logic f);
      valid_f = v; taken_f = t; stall_d = s; flush_d = f;
      instr_f = {$urandom, $urandom};
      pc_f = {$urandom, $urandom};
   endtask

   initial begin
      rst_n = 1'b0; stall_d = 0; flush_d = 0; perf_clr = 0;
      valid_f = '0; taken_f = '0; instr_f = '0; pc_f = '0;
      model_reset();
      #12;
      compare();
      @(posedge clk); #1;
      rst_n = 1'b1;
      // load with pc+4
      drive(2'b11, 2'b00, 0, 0);
      pc_f = {32'h104, 32'h100};
      step();
      // in-packet kill
      drive(2'b11, 2'b01, 0, 0);
      step();
      check("kill_lane1_instr", 128'(instr_d[63:32]), 128'(NOP));
      // stall three cycles then stall+flush
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 2'b00, 1, 0);
         step();
      end
      drive(2'b11, 2'b10, 1, 1);
      step();
      // wrap of pc+4
      drive(2'b11, 2'b00, 0, 0);
      pc_f[31:0] = 32'hFFFF_FFFC;
      step();
      check("wrap_pc4", 128'(pc4_d[31:0]), 128'(0));
      // long stall saturates a narrow counter, then clear under stall
      for (int i = 0; i < 20; i++) begin
         drive($urandom, $urandom, 1, 0);
         step();
      end
      perf_clr = 1;
      step();
      perf_clr = 0;
      // async reset while both lanes valid
      drive(2'b11, 2'b00, 0, 0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare();
      @(posedge clk); #1;
      compare();
      rst_n = 1'b1;
      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         drive($urandom, $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
         perf_clr = ($urandom_range(0, 15) == 0);
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
